// File: rtl/fill_valve_pkg.sv
// Shared constants, state encoding and sizing helpers for the fill valve arbiter.
package fill_valve_pkg;

  localparam int N_MACHINES_DEF  = 4;
  localparam int FILL_CYCLES_DEF = 60;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int FILL_LIMIT_DEF  = 120;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t FILL   = 2'd1;
  localparam state_t SETTLE = 2'd2;

  // Wide enough to hold the larger of the fill length and the timeout limit.
  function automatic int cnt_width(input int fill_cycles, input int fill_limit);
    return $clog2(((fill_cycles > fill_limit) ? fill_cycles : fill_limit) + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fill_valve_arbiter_if.sv
// Machine-side bundle of the shared water inlet valve: requests in, grant/valve status out.
interface fill_valve_arbiter_if
  import fill_valve_pkg::*;
#(
  parameter int N_MACHINES = N_MACHINES_DEF
);
  logic [N_MACHINES-1:0] req;
  logic [N_MACHINES-1:0] pause;
  logic [N_MACHINES-1:0] grant;
  logic                  valve_open;
  logic [N_MACHINES-1:0] fill_done;
  logic                  busy;
  logic [N_MACHINES-1:0] timeout_err;

  modport master (
    output req, pause,
    input  grant, valve_open, fill_done, busy, timeout_err
  );

  modport slave (
    input  req, pause,
    output grant, valve_open, fill_done, busy, timeout_err
  );
endinterface

// File: rtl/fill_valve_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping to 0.
module rr_picker
  import fill_valve_pkg::*;
#(
  parameter int N_MACHINES = N_MACHINES_DEF,
  parameter int IDX_W      = idx_width(N_MACHINES_DEF)
) (
  input  logic [N_MACHINES-1:0] req,
  input  logic [IDX_W-1:0]      last_grant,
  output logic [N_MACHINES-1:0] pick
);

  always_comb begin : search
    logic             found;
    logic [IDX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_MACHINES; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N_MACHINES);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Shares one water inlet valve among N_MACHINES washers (IDLE -> FILL -> SETTLE).
// Define FILL_TIMEOUT_EN to add the per-grant fill timeout and sticky timeout_err flags.
module fill_valve_arbiter
  import fill_valve_pkg::*;
#(
  parameter int N_MACHINES  = N_MACHINES_DEF,
  parameter int FILL_CYCLES = FILL_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int FILL_LIMIT  = FILL_LIMIT_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  fill_valve_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(N_MACHINES);
  localparam int CNT_W = cnt_width(FILL_CYCLES, FILL_LIMIT);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      last_grant;
  logic [N_MACHINES-1:0] grant_q;
  logic                  valve_q;
  logic [N_MACHINES-1:0] done_q;
  logic [N_MACHINES-1:0] pick;
  logic [IDX_W-1:0]      win_idx;

  rr_picker #(
    .N_MACHINES (N_MACHINES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req        (bus.req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MACHINES; i++) begin
      if (pick[i]) win_idx = IDX_W'(i);
    end
  end

`ifdef FILL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(FILL_LIMIT - 1);
  logic [CNT_W-1:0]      timer;
  logic [N_MACHINES-1:0] terr_q;
`endif

  // last_grant doubles as the index of the current owner while in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(N_MACHINES - 1);
      grant_q    <= '0;
      valve_q    <= 1'b0;
      done_q     <= '0;
`ifdef FILL_TIMEOUT_EN
      timer      <= '0;
      terr_q     <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state      <= FILL;
            grant_q    <= pick;
            last_grant <= win_idx;
            valve_q    <= ~|(pick & bus.pause);
            cnt        <= '0;
`ifdef FILL_TIMEOUT_EN
            timer      <= '0;
`endif
          end
        end
        FILL: begin
`ifdef FILL_TIMEOUT_EN
          timer <= timer + 1'b1;
`endif
          if (!bus.req[last_grant]) begin
            state   <= SETTLE;
            grant_q <= '0;
            valve_q <= 1'b0;
            cnt     <= '0;
          end else if (!bus.pause[last_grant] && (cnt == FILL_LAST)) begin
            state              <= SETTLE;
            grant_q            <= '0;
            valve_q            <= 1'b0;
            cnt                <= '0;
            done_q[last_grant] <= 1'b1;
`ifdef FILL_TIMEOUT_EN
          end else if (timer == LIMIT_LAST) begin
            state              <= SETTLE;
            grant_q            <= '0;
            valve_q            <= 1'b0;
            cnt                <= '0;
            terr_q[last_grant] <= 1'b1;
`endif
          end else if (bus.pause[last_grant]) begin
            valve_q <= 1'b0;
          end else begin
            cnt     <= cnt + 1'b1;
            valve_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.valve_open = valve_q;
  assign bus.fill_done  = done_q;
  assign bus.busy       = (state != IDLE);
`ifdef FILL_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = '0;
`endif

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Directed self-checking bench for fill_valve_arbiter (4 machines, 60-cycle fills, 2-cycle gaps).
module tb_fill_valve_arbiter;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  fill_valve_arbiter_if #(.N_MACHINES(4)) bus();

  fill_valve_arbiter #(
    .N_MACHINES  (4),
    .FILL_CYCLES (60),
    .GAP_CYCLES  (2),
    .FILL_LIMIT  (120)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.pause = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.pause = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant); end
    tests_run++;
    if (bus.valve_open !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valve: got %b expected 0", bus.valve_open); end
    tests_run++;
    if (bus.fill_done !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0000", bus.fill_done); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_terr: got %b expected 0000", bus.timeout_err); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_no_req_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single_fill;
    int open_n;
    int early;
    open_n = 0;
    early  = 0;
    bus.req = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_grant: got %b expected 0001", bus.grant); end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
    for (int i = 1; i <= 60; i++) begin
      if (bus.valve_open) open_n++;
      if (bus.fill_done != 4'b0000) early++;
      @(negedge clk);
    end
    tests_run++;
    if (open_n !== 60) begin tests_failed++; $display("[TB] FAIL single_open_cycles: got %0d expected 60", open_n); end
    tests_run++;
    if (early !== 0) begin tests_failed++; $display("[TB] FAIL single_early_done: got %0d expected 0", early); end
    tests_run++;
    if (bus.fill_done !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_done: got %b expected 0001", bus.fill_done); end
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.valve_open !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_settle_outputs: got grant %b valve %b expected 0000/0", bus.grant, bus.valve_open);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (bus.fill_done !== 4'b0000 || bus.busy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_settle2: got done %b busy %b expected 0000/1", bus.fill_done, bus.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_back_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    int budget;
    int settle_n;
    int idle_n;
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp = 4'(1 << k);
      budget = 0;
      while (bus.grant == 4'b0000 && budget < 10) begin @(negedge clk); budget++; end
      tests_run++;
      if (bus.grant !== exp) begin tests_failed++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, bus.grant, exp); end
      budget = 0;
      while (bus.fill_done == 4'b0000 && budget < 100) begin @(negedge clk); budget++; end
      tests_run++;
      if (bus.fill_done !== exp) begin tests_failed++; $display("[TB] FAIL rr_done%0d: got %b expected %b", k, bus.fill_done, exp); end
      bus.req[k] = 1'b0;
      if (k < 3) begin
        settle_n = 1;
        idle_n   = 0;
        budget   = 0;
        @(negedge clk);
        while (bus.grant == 4'b0000 && budget < 10) begin
          if (bus.busy) settle_n++; else idle_n++;
          @(negedge clk);
          budget++;
        end
        tests_run++;
        if (settle_n !== 2 || idle_n !== 1) begin
          tests_failed++; $display("[TB] FAIL rr_gap%0d: got settle %0d idle %0d expected 2/1", k, settle_n, idle_n);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pause;
    int closed_n;
    int open_n;
    int done_at;
    int budget;
    closed_n = 0;
    open_n   = 0;
    done_at  = 0;
    do_reset();
    bus.req = 4'b0010;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (bus.fill_done != 4'b0000) begin done_at = i; break; end
      if (bus.valve_open) open_n++; else closed_n++;
      if (i == 1) begin
        tests_run++;
        if (bus.grant !== 4'b0010) begin tests_failed++; $display("[TB] FAIL pause_grant: got %b expected 0010", bus.grant); end
      end
      if (i == 31) begin bus.pause[1] = 1'b1; bus.req[3] = 1'b1; end
      if (i == 35) begin
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.valve_open !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL pause_hold: got grant %b valve %b expected 0010/0", bus.grant, bus.valve_open);
        end
      end
      if (i == 41) bus.pause[1] = 1'b0;
    end
    tests_run++;
    if (done_at !== 71) begin tests_failed++; $display("[TB] FAIL pause_done_time: got %0d expected 71", done_at); end
    tests_run++;
    if (closed_n !== 10 || open_n !== 60) begin
      tests_failed++; $display("[TB] FAIL pause_valve_cycles: got closed %0d open %0d expected 10/60", closed_n, open_n);
    end
    tests_run++;
    if (bus.fill_done !== 4'b0010) begin tests_failed++; $display("[TB] FAIL pause_done: got %b expected 0010", bus.fill_done); end
    bus.req[1] = 1'b0;
    budget = 0;
    while (bus.grant == 4'b0000 && budget < 10) begin @(negedge clk); budget++; end
    tests_run++;
    if (bus.grant !== 4'b1000) begin tests_failed++; $display("[TB] FAIL pause_next: got %b expected 1000", bus.grant); end
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort;
    int spurious;
    spurious = 0;
    do_reset();
    bus.req = 4'b1100;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus.fill_done != 4'b0000) spurious++;
      if (i == 1) begin
        tests_run++;
        if (bus.grant !== 4'b0100) begin tests_failed++; $display("[TB] FAIL abort_grant: got %b expected 0100", bus.grant); end
      end
      if (i == 21) bus.req[2] = 1'b0;
      if (i == 22) begin
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.valve_open !== 1'b0 || bus.busy !== 1'b1) begin
          tests_failed++; $display("[TB] FAIL abort_settle: got grant %b valve %b busy %b expected 0000/0/1", bus.grant, bus.valve_open, bus.busy);
        end
      end
      if (i == 24) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_idle: got %b expected 0", bus.busy); end
      end
      if (i == 25) begin
        tests_run++;
        if (bus.grant !== 4'b1000) begin tests_failed++; $display("[TB] FAIL abort_next: got %b expected 1000", bus.grant); end
      end
    end
    tests_run++;
    if (spurious !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d expected 0", spurious); end
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("[TB] FAIL abort_no_err: got %b expected 0000", bus.timeout_err); end
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.req = 4'b0001;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.valve_open !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL areset_pre: got grant %b valve %b expected 0001/1", bus.grant, bus.valve_open);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.valve_open !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL areset_outputs: got grant %b valve %b expected 0000/0", bus.grant, bus.valve_open);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.fill_done !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL areset_status: got busy %b done %b expected 0/0000", bus.busy, bus.fill_done);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef FILL_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    bus.req = 4'b0001;
    for (int i = 1; i <= 125; i++) begin
      @(negedge clk);
      if (i == 11) bus.pause[0] = 1'b1;
      if (i == 120) begin
        tests_run++;
        if (bus.timeout_err !== 4'b0000 || bus.grant !== 4'b0001) begin
          tests_failed++; $display("[TB] FAIL timeout_early: got err %b grant %b expected 0000/0001", bus.timeout_err, bus.grant);
        end
      end
      if (i == 121) begin
        tests_run++;
        if (bus.timeout_err !== 4'b0001 || bus.grant !== 4'b0000) begin
          tests_failed++; $display("[TB] FAIL timeout_set: got err %b grant %b expected 0001/0000", bus.timeout_err, bus.grant);
        end
        tests_run++;
        if (bus.fill_done !== 4'b0000) begin tests_failed++; $display("[TB] FAIL timeout_no_done: got %b expected 0000", bus.fill_done); end
        bus.req = 4'b0000;
      end
    end
    tests_run++;
    if (bus.timeout_err !== 4'b0001) begin tests_failed++; $display("[TB] FAIL timeout_sticky: got %b expected 0001", bus.timeout_err); end
    bus.pause = 4'b0000;
    do_reset();
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("[TB] FAIL timeout_cleared: got %b expected 0000", bus.timeout_err); end
  endtask
`else
  task automatic test_timeout;
    do_reset();
    bus.req = 4'b0001;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i == 11) bus.pause[0] = 1'b1;
    end
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.valve_open !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL pause_indefinite: got grant %b valve %b expected 0001/0", bus.grant, bus.valve_open);
    end
    tests_run++;
    if (bus.timeout_err !== 4'b0000) begin tests_failed++; $display("[TB] FAIL terr_tied: got %b expected 0000", bus.timeout_err); end
    bus.pause = 4'b0000;
    bus.req   = 4'b0000;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.pause    = '0;
    test_reset();
    test_single_fill();
    test_round_robin();
    test_pause();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fill_valve_arbiter.md
FILL_VALVE_ARBITER -- requirements
Module: fill_valve_arbiter

Interface
REQ-001 SHALL have parameter N_MACHINES, default 4, number of washing machines sharing one water inlet valve.
REQ-002 SHALL have parameter FILL_CYCLES, default 60, active valve-open cycles per fill (1 minute at 1 clk/s).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, valve-closed settle cycles between grants.
REQ-004 SHALL have parameter FILL_LIMIT, default 120, max cycles in FILL per grant, paused cycles included; used only with FILL_TIMEOUT_EN.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port req  input  N_MACHINES  per-machine fill request, level, held until fill_done or abandon.
REQ-008 SHALL have port pause  input  N_MACHINES  per-machine time_pause, level.
REQ-009 SHALL have port grant  output  N_MACHINES  one-hot or zero, registered, machine owning valve.
REQ-010 SHALL have port valve_open  output  1  registered valve drive.
REQ-011 SHALL have port fill_done  output  N_MACHINES  one-cycle pulse, fill completed.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  N_MACHINES  sticky per-machine timeout flag (tied 0 without FILL_TIMEOUT_EN).

Function
REQ-014 SHALL implement states IDLE, FILL, SETTLE; never more than one grant bit set.
REQ-015 IDLE: if any req bit high at edge k, SHALL select winner round-robin (search starts at last_grant+1, wraps at N_MACHINES-1 to 0), enter FILL with grant one-hot and counter=0 after edge k.
REQ-016 FILL: valve_open SHALL equal ~pause[g] for granted g, registered with grant; counter increments only on cycles with req[g]=1 and pause[g]=0.
REQ-017 FILL: pause[g]=1 SHALL freeze counter, close valve, keep grant; other requesters stay blocked.
REQ-018 FILL: counter reaching FILL_CYCLES-1 on an unpaused cycle SHALL pulse fill_done[g] for exactly one cycle, coincident with the FILL->SETTLE transition edge; exactly FILL_CYCLES valve-open cycles.
REQ-019 FILL: req[g] dropping SHALL abort to SETTLE next edge, no fill_done, no error.
REQ-020 SETTLE: grant=0, valve_open=0 for exactly GAP_CYCLES cycles, then IDLE; requests arriving meanwhile wait.
REQ-021 last_grant SHALL update on every grant; a machine that just finished is lowest priority next arbitration.
REQ-022 Counters SHALL be $clog2(max(FILL_CYCLES,FILL_LIMIT)+1) bits, no wrap during valid operation.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, grant=0, valve_open=0, fill_done=0, busy=0, timeout_err=0, counters=0, last_grant=N_MACHINES-1 (machine 0 first priority).
REQ-024 Reset mid-FILL SHALL close valve asynchronously; no fill_done issued.

Configuration
REQ-025 Macro FILL_TIMEOUT_EN defined: separate timer counts every FILL cycle; at FILL_LIMIT cycles without completion SHALL set timeout_err[g] (sticky until reset), go SETTLE, no fill_done.
REQ-026 Macro FILL_TIMEOUT_EN undefined: no timer logic, timeout_err constant 0, pause may hold grant indefinitely.

Structure
REQ-027 Package fill_valve_pkg SHALL hold the state enum (IDLE, FILL, SETTLE) and default parameter constants.
REQ-028 Round-robin selection SHALL be sub-module rr_picker (combinational, inputs req/last_grant, output one-hot); rest in fill_valve_arbiter.

Verification
REQ-029 Reset then req=4'b0001 held -> grant=0001 one edge later, valve_open high exactly 60 cycles, fill_done[0] single pulse, 2 settle cycles, then IDLE.
REQ-030 req=4'b1111 held, each dropping after its fill_done -> grant order 0001,0010,0100,1000, 2-cycle gaps.
REQ-031 Machine 1 granted, pause[1] high 10 cycles at count 30 -> valve closed 10 cycles, fill_done after 70 cycles total.
REQ-032 req[2] dropped at count 20 -> SETTLE next edge, no fill_done[2], next requester served after gap.
REQ-033 FILL_TIMEOUT_EN, pause[0] held at count 10 -> timeout_err[0]=1 at cycle 120, grant released, flag holds until rst_n low.
REQ-034 rst_n low mid-FILL -> grant=0 and valve_open=0 before next clock edge.
